// File: rtl/vedic16_seq_ctrl.sv
// ============================================================================
// vedic16_seq_ctrl : 16x16 unsigned multiplier, one Vedic 8x8 core over 4 steps
// Revision: 1.0
// ============================================================================
`default_nettype none

module vedic2x2 (
  input  logic [1:0] x_i,
  input  logic [1:0] y_i,
  output logic [3:0] p_o
);
  logic w_cross0, w_cross1, w_carry, w_hi;

  assign w_cross0 = x_i[1] & y_i[0];
  assign w_cross1 = x_i[0] & y_i[1];
  assign w_hi     = x_i[1] & y_i[1];
  assign w_carry  = w_cross0 & w_cross1;

  assign p_o[0] = x_i[0] & y_i[0];
  assign p_o[1] = w_cross0 ^ w_cross1;
  assign p_o[2] = w_hi ^ w_carry;
  assign p_o[3] = w_hi & w_carry;
endmodule

module vedic4x4 (
  input  logic [3:0] x_i,
  input  logic [3:0] y_i,
  output logic [7:0] p_o
);
  logic [3:0] q [4];
  logic [4:0] mid;

  // q[0]=lo*lo, q[1]=hi*lo, q[2]=lo*hi, q[3]=hi*hi (Urdhva-Tiryagbhyam split)
  for (genvar i = 0; i < 4; i++) begin : g_pp
    vedic2x2 u_pp (
      .x_i (x_i[2*(i%2) +: 2]),
      .y_i (y_i[2*(i/2) +: 2]),
      .p_o (q[i])
    );
  end

  assign mid = {1'b0, q[1]} + {1'b0, q[2]};
  assign p_o = {4'b0, q[0]} + {1'b0, mid, 2'b0} + {q[3], 4'b0};
endmodule

module vedic8x8 (
  input  logic [7:0]  x_i,
  input  logic [7:0]  y_i,
  output logic [15:0] p_o
);
  logic [7:0] q [4];
  logic [8:0] mid;

  for (genvar i = 0; i < 4; i++) begin : g_pp
    vedic4x4 u_pp (
      .x_i (x_i[4*(i%2) +: 4]),
      .y_i (y_i[4*(i/2) +: 4]),
      .p_o (q[i])
    );
  end

  assign mid = {1'b0, q[1]} + {1'b0, q[2]};
  assign p_o = {8'b0, q[0]} + {3'b0, mid, 4'b0} + {q[3], 8'b0};
endmodule

module vedic16_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] prod,
  output logic        busy
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [15:0] a_q, b_q;
  logic [31:0] acc_q, acc_d;
  logic        load;

  logic [7:0]  mul_x, mul_y;
  logic [15:0] mul_p;
  logic [31:0] addend;

  // step[1] selects the a half, step[0] the b half
  assign mul_x = step_q[1] ? a_q[15:8] : a_q[7:0];
  assign mul_y = step_q[0] ? b_q[15:8] : b_q[7:0];

  vedic8x8 u_core (
    .x_i (mul_x),
    .y_i (mul_y),
    .p_o (mul_p)
  );

  always_comb begin
    addend = {16'b0, mul_p};
    case (step_q)
      2'd0:    addend = {16'b0, mul_p};
      2'd3:    addend = {mul_p, 16'b0};
      default: addend = {8'b0, mul_p, 8'b0};
    endcase
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          acc_d   = 32'd0;
          step_d  = 2'd0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        acc_d = acc_q + addend;
        if (step_q == 2'd3) begin
          step_d  = 2'd0;
          state_d = S_DONE;
        end else begin
          step_d = step_q + 2'd1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        step_d  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= 2'd0;
      acc_q   <= 32'd0;
      a_q     <= 16'd0;
      b_q     <= 16'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      if (load) begin
        a_q <= a;
        b_q <= b;
      end
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign prod      = acc_q;
endmodule

`default_nettype wire
